// File: rtl/crossyroad_pkg.sv
// crossyroad_pkg: shared definitions for the crossyroad game sequencer.
// Holds the game-state encoding, the coordinate width, the default visible
// width and the lane-direction rule used by every lane.
package crossyroad_pkg;

  localparam int COORD_W          = 10;
  localparam int H_ACTIVE_DEFAULT = 640;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HOP  = 2'd2,
    DEAD = 2'd3
  } game_state_t;

  // Odd lanes drive to the right, even lanes to the left.
  function automatic logic lane_moves_right(input int unsigned lane);
    return lane[0];
  endfunction

endpackage

// File: rtl/crossy_lane_car.sv
// crossy_lane_car: one traffic lane's car position.
// Ports:
//   clk, sys_rst   clock, asynchronous active-low reset
//   level          current difficulty, added to the lane index for speed
//   frame_tick     one-cycle pulse per video frame; the car moves on it
//   freeze         holds the car still (player is dead)
//   x              car left edge in pixels, 0..H_ACTIVE-1
//   overlap        the position being loaded this cycle overlaps the player
//                  column, so the controller can react on the same edge
module crossy_lane_car
  import crossyroad_pkg::*;
#(
  parameter int LANE     = 1,
  parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
  parameter int PLAYER_X = 304,
  parameter int PLAYER_W = 32,
  parameter int CAR_W    = 64
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  logic [2:0]         level,
  input  logic               frame_tick,
  input  logic               freeze,
  output logic [COORD_W-1:0] x,
  output logic               overlap
);

  localparam logic [10:0]        H_ACT11 = 11'(H_ACTIVE);
  localparam logic [10:0]        HIT_LO  = 11'(PLAYER_X);
  localparam logic [10:0]        HIT_HI  = 11'(PLAYER_X + PLAYER_W);
  localparam logic [10:0]        CAR_W11 = 11'(CAR_W);
  localparam logic [COORD_W-1:0] X_RESET = COORD_W'(((LANE - 1) * 128) % H_ACTIVE);

  logic [10:0] speed;
  logic [10:0] x_ext;
  logic [10:0] sum;
  logic [10:0] x_nxt11;

  // Wrap arithmetic is done on 11 bits so x+speed never overflows before
  // the modulus is applied.
  always_comb begin
    speed   = 11'(LANE) + {8'd0, level};
    x_ext   = {1'b0, x};
    sum     = x_ext + speed;
    x_nxt11 = x_ext;
    if (frame_tick && !freeze) begin
      if (lane_moves_right(LANE)) begin
        x_nxt11 = (sum >= H_ACT11) ? sum - H_ACT11 : sum;
      end else begin
        x_nxt11 = (x_ext >= speed) ? x_ext - speed : x_ext + H_ACT11 - speed;
      end
    end
    overlap = (x_nxt11 < HIT_HI) && ((x_nxt11 + CAR_W11) > HIT_LO);
  end

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      x <= X_RESET;
    end else begin
      x <= x_nxt11[COORD_W-1:0];
    end
  end

endmodule

// File: rtl/crossy_game_ctrl.sv
// crossy_game_ctrl: per-frame game sequencer for the crossyroad VGA demo.
// Owns the player row, hop animation, lane cars, collision, score and level.
// Ports:
//   clk, sys_rst   clock, asynchronous active-low reset
//   move           raw player button (asynchronous, synchronised here)
//   frame_tick     one-cycle pulse per video frame
//   player_row     0 start row, 1..NUM_LANES lanes, NUM_LANES+1 goal row
//   hop_phase      remaining hop frames, 0 when not hopping
//   car_x          packed car x, lane i at bits [10*i-1 : 10*(i-1)]
//   score, level   goals reached (sat 255) and difficulty (sat 7)
//   game_state     IDLE=0 PLAY=1 HOP=2 DEAD=3
//   dead           high while in DEAD
// Build option: define CROSSY_GODMODE_EN to disable collisions entirely.
module crossy_game_ctrl
  import crossyroad_pkg::*;
#(
  parameter int NUM_LANES   = 4,
  parameter int H_ACTIVE    = H_ACTIVE_DEFAULT,
  parameter int PLAYER_X    = 304,
  parameter int PLAYER_W    = 32,
  parameter int CAR_W       = 64,
  parameter int HOP_FRAMES  = 8,
  parameter int DEAD_FRAMES = 120
) (
  input  logic                         clk,
  input  logic                         sys_rst,
  input  logic                         move,
  input  logic                         frame_tick,
  output logic [2:0]                   player_row,
  output logic [3:0]                   hop_phase,
  output logic [NUM_LANES*COORD_W-1:0] car_x,
  output logic [7:0]                   score,
  output logic [2:0]                   level,
  output logic [1:0]                   game_state,
  output logic                         dead
);

  localparam logic [2:0] GOAL_ROW = 3'(NUM_LANES + 1);

  game_state_t state, state_nxt;
  logic [2:0] row_nxt;
  logic [3:0] phase_nxt;
  logic [7:0] score_nxt;
  logic [2:0] level_nxt;
  logic [7:0] dead_cnt, dead_cnt_nxt;
  logic       move_pend, pend_nxt;
  logic       move_meta, move_sync, move_prev;
  logic       move_edge;
  logic       hit;
  logic       cars_frozen;
  logic [NUM_LANES-1:0] lane_overlap;

  assign move_edge   = move_sync & ~move_prev;
  assign cars_frozen = (state == DEAD);
  assign game_state  = state;

`ifdef CROSSY_GODMODE_EN
  assign dead = 1'b0;
`else
  assign dead = (state == DEAD);
`endif

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    crossy_lane_car #(
      .LANE     (g + 1),
      .H_ACTIVE (H_ACTIVE),
      .PLAYER_X (PLAYER_X),
      .PLAYER_W (PLAYER_W),
      .CAR_W    (CAR_W)
    ) u_lane (
      .clk        (clk),
      .sys_rst    (sys_rst),
      .level      (level),
      .frame_tick (frame_tick),
      .freeze     (cars_frozen),
      .x          (car_x[COORD_W*g +: COORD_W]),
      .overlap    (lane_overlap[g])
    );
  end

  // Button synchroniser; move_prev gives a single edge per press.
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      move_meta <= 1'b0;
      move_sync <= 1'b0;
      move_prev <= 1'b0;
    end else begin
      move_meta <= move;
      move_sync <= move_meta;
      move_prev <= move_sync;
    end
  end

  // Next-state logic. An edge arriving with frame_tick counts as pending.
  // The collision check runs last so it overrides every other transition,
  // and it looks at the row being loaded this edge.
  always_comb begin
    state_nxt    = state;
    row_nxt      = player_row;
    phase_nxt    = hop_phase;
    score_nxt    = score;
    level_nxt    = level;
    dead_cnt_nxt = dead_cnt;
    pend_nxt     = move_pend;
    hit          = 1'b0;

    unique case (state)
      IDLE: begin
        pend_nxt = 1'b0;
        if (move_edge) begin
          state_nxt = PLAY;
          score_nxt = 8'd0;
          level_nxt = 3'd0;
        end
      end
      PLAY: begin
        pend_nxt = move_pend | move_edge;
        if (frame_tick && (move_pend || move_edge)) begin
          state_nxt = HOP;
          row_nxt   = player_row + 3'd1;
          phase_nxt = 4'(HOP_FRAMES - 1);
          pend_nxt  = 1'b0;
        end
      end
      HOP: begin
        pend_nxt = 1'b0;
        if (frame_tick) begin
          if (hop_phase == 4'd0) begin
            state_nxt = PLAY;
            if (player_row == GOAL_ROW) begin
              score_nxt = (score == 8'hFF) ? score : score + 8'd1;
              level_nxt = (level == 3'd7) ? level : level + 3'd1;
              row_nxt   = 3'd0;
            end
          end else begin
            phase_nxt = hop_phase - 4'd1;
          end
        end
      end
      DEAD: begin
        pend_nxt = 1'b0;
        if (frame_tick) begin
          if (dead_cnt <= 8'd1) begin
            state_nxt    = IDLE;
            row_nxt      = 3'd0;
            dead_cnt_nxt = 8'd0;
          end else begin
            dead_cnt_nxt = dead_cnt - 8'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

`ifndef CROSSY_GODMODE_EN
    if (frame_tick && (state == PLAY || state == HOP)) begin
      for (int i = 1; i <= NUM_LANES; i++) begin
        if (row_nxt == 3'(i) && lane_overlap[i-1]) hit = 1'b1;
      end
    end
`endif

    if (hit) begin
      state_nxt    = DEAD;
      dead_cnt_nxt = 8'(DEAD_FRAMES);
      pend_nxt     = 1'b0;
      phase_nxt    = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state      <= IDLE;
      player_row <= 3'd0;
      hop_phase  <= 4'd0;
      score      <= 8'd0;
      level      <= 3'd0;
      dead_cnt   <= 8'd0;
      move_pend  <= 1'b0;
    end else begin
      state      <= state_nxt;
      player_row <= row_nxt;
      hop_phase  <= phase_nxt;
      score      <= score_nxt;
      level      <= level_nxt;
      dead_cnt   <= dead_cnt_nxt;
      move_pend  <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_crossy_game_ctrl.sv
// tb_crossy_game_ctrl: self-checking bench for crossy_game_ctrl.
// A behavioural model (plain integer arithmetic) tracks the game; each test
// task drives presses and frame ticks and compares the DUT against it.
// Honours CROSSY_GODMODE_EN the same way the design does.
module tb_crossy_game_ctrl;

  localparam int NL = 4;
  localparam int HA = 640;
  localparam int PX = 304;
  localparam int PW = 32;
  localparam int CW = 64;
  localparam int HF = 8;
  localparam int DF = 120;

`ifdef CROSSY_GODMODE_EN
  localparam bit GOD = 1'b1;
`else
  localparam bit GOD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        move;
  logic        frame_tick;
  logic [2:0]  player_row;
  logic [3:0]  hop_phase;
  logic [39:0] car_x;
  logic [7:0]  score;
  logic [2:0]  level;
  logic [1:0]  game_state;
  logic        dead;

  int checks = 0;
  int passes = 0;

  // Behavioural model state.
  int m_state, m_row, m_phase, m_score, m_level, m_dcnt;
  bit m_pend;
  int m_x [1:NL];

  always #5 clk = ~clk;

  crossy_game_ctrl dut (
    .clk        (clk),
    .sys_rst    (sys_rst),
    .move       (move),
    .frame_tick (frame_tick),
    .player_row (player_row),
    .hop_phase  (hop_phase),
    .car_x      (car_x),
    .score      (score),
    .level      (level),
    .game_state (game_state),
    .dead       (dead)
  );

  function automatic bit in_hit_zone(input int x);
    return (x < PX + PW) && (x + CW > PX);
  endfunction

  function automatic logic [39:0] model_car_x();
    logic [39:0] v;
    v = '0;
    for (int i = 1; i <= NL; i++) v[10*(i-1) +: 10] = 10'(m_x[i]);
    return v;
  endfunction

  function automatic int lane_pos_after(input int lane, input int k);
    int s, p;
    s = lane + m_level;
    if (lane % 2 == 1) p = (m_x[lane] + k * s) % HA;
    else p = ((m_x[lane] - k * s) % HA + HA) % HA;
    return p;
  endfunction

  // True when five immediate back-to-back hops from row 0 avoid every car.
  function automatic bit crossing_safe();
    for (int j = 1; j <= NL; j++)
      for (int k = (HF + 1) * (j - 1) + 1; k <= (HF + 1) * j; k++)
        if (in_hit_zone(lane_pos_after(j, k))) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_row = 0; m_phase = 0; m_score = 0; m_level = 0;
    m_dcnt = 0; m_pend = 1'b0;
    for (int i = 1; i <= NL; i++) m_x[i] = ((i - 1) * 128) % HA;
  endtask

  task automatic model_press();
    if (m_state == 0) begin
      m_state = 1; m_score = 0; m_level = 0; m_pend = 1'b0;
    end else if (m_state == 1) begin
      m_pend = 1'b1;
    end
  endtask

  task automatic model_tick();
    int prev;
    int s;
    prev = m_state;
    if (m_state != 3) begin
      for (int i = 1; i <= NL; i++) begin
        s = i + m_level;
        if (i % 2 == 1) m_x[i] = (m_x[i] + s) % HA;
        else m_x[i] = (m_x[i] - s + HA) % HA;
      end
    end
    case (m_state)
      1: if (m_pend) begin
        m_state = 2; m_row = m_row + 1; m_phase = HF - 1; m_pend = 1'b0;
      end
      2: if (m_phase == 0) begin
        m_state = 1;
        if (m_row == NL + 1) begin
          m_score = (m_score < 255) ? m_score + 1 : 255;
          m_level = (m_level < 7) ? m_level + 1 : 7;
          m_row = 0;
        end
      end else begin
        m_phase = m_phase - 1;
      end
      3: begin
        m_dcnt = m_dcnt - 1;
        if (m_dcnt == 0) begin m_state = 0; m_row = 0; end
      end
      default: ;
    endcase
    if (!GOD && (prev == 1 || prev == 2) && m_row >= 1 && m_row <= NL &&
        in_hit_zone(m_x[m_row])) begin
      m_state = 3; m_dcnt = DF; m_pend = 1'b0; m_phase = 0;
    end
  endtask

  task automatic do_reset();
    sys_rst = 1'b0; move = 1'b0; frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    sys_rst = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  task automatic press();
    @(negedge clk) move = 1'b1;
    repeat (4) @(negedge clk);
    move = 1'b0;
    repeat (3) @(negedge clk);
    model_press();
  endtask

  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    model_tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (game_state !== 2'd0 || player_row !== 3'd0 || hop_phase !== 4'd0)
      $display("[TB] FAIL reset_ctrl: got st=%0d row=%0d ph=%0d expected 0/0/0", game_state, player_row, hop_phase);
    else passes++;
    checks++; if (score !== 8'd0 || level !== 3'd0 || dead !== 1'b0)
      $display("[TB] FAIL reset_score: got sc=%0d lv=%0d dead=%0d expected 0/0/0", score, level, dead);
    else passes++;
    checks++; if (car_x !== {10'd384, 10'd256, 10'd128, 10'd0})
      $display("[TB] FAIL reset_cars: got %h expected %h", car_x, {10'd384, 10'd256, 10'd128, 10'd0});
    else passes++;
    press(); press(); tick(); tick();
    checks++; if (game_state !== 2'(m_state) || hop_phase !== 4'(m_phase))
      $display("[TB] FAIL pre_reset_hop: got st=%0d ph=%0d expected %0d/%0d", game_state, hop_phase, m_state, m_phase);
    else passes++;
    @(negedge clk);
    #2 sys_rst = 1'b0;
    #1;
    checks++; if (game_state !== 2'd0 || player_row !== 3'd0 || hop_phase !== 4'd0 || dead !== 1'b0)
      $display("[TB] FAIL async_reset_ctrl: got st=%0d row=%0d ph=%0d dead=%0d expected 0", game_state, player_row, hop_phase, dead);
    else passes++;
    checks++; if (car_x !== {10'd384, 10'd256, 10'd128, 10'd0})
      $display("[TB] FAIL async_reset_cars: got %h expected %h", car_x, {10'd384, 10'd256, 10'd128, 10'd0});
    else passes++;
    @(negedge clk) sys_rst = 1'b1;
    model_reset();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int n = 1; n <= 640; n++) begin
      tick();
      if (n == 64) begin
        checks++; if (car_x[19:10] !== 10'd0)
          $display("[TB] FAIL wrap_lane2_zero: got %0d expected 0", car_x[19:10]);
        else passes++;
      end
      if (n == 65) begin
        checks++; if (car_x[19:10] !== 10'd638)
          $display("[TB] FAIL wrap_lane2_under: got %0d expected 638", car_x[19:10]);
        else passes++;
      end
      if (n == 639) begin
        checks++; if (car_x[9:0] !== 10'd639)
          $display("[TB] FAIL wrap_lane1_top: got %0d expected 639", car_x[9:0]);
        else passes++;
      end
      if (n == 640) begin
        checks++; if (car_x[9:0] !== 10'd0)
          $display("[TB] FAIL wrap_lane1_over: got %0d expected 0", car_x[9:0]);
        else passes++;
        checks++; if (car_x !== model_car_x())
          $display("[TB] FAIL wrap_all: got %h expected %h", car_x, model_car_x());
        else passes++;
      end
    end
  endtask

  task automatic test_hop();
    int exp_st, exp_ph;
    do_reset();
    press();
    @(negedge clk) move = 1'b1;
    repeat (4) @(negedge clk);
    model_press();
    for (int k = 1; k <= 50; k++) begin
      tick();
      exp_st = (k <= HF) ? 2 : 1;
      exp_ph = (k <= HF) ? HF - k : 0;
      checks++; if (game_state !== 2'(exp_st) || hop_phase !== 4'(exp_ph) || player_row !== 3'd1)
        $display("[TB] FAIL hold_hop_k%0d: got st=%0d ph=%0d row=%0d expected %0d/%0d/1",
                 k, game_state, hop_phase, player_row, exp_st, exp_ph);
      else passes++;
    end
    move = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_collision();
    do_reset();
    press();
    repeat (240) tick();
    press();
    tick();
    checks++; if (car_x[9:0] !== 10'd241)
      $display("[TB] FAIL coll_lane1_x: got %0d expected 241", car_x[9:0]);
    else passes++;
    checks++; if (game_state !== 2'(m_state) || dead !== (m_state == 3) || player_row !== 3'd1)
      $display("[TB] FAIL coll_land: got st=%0d dead=%0d row=%0d expected %0d/%0d/1",
               game_state, dead, player_row, m_state, m_state == 3);
    else passes++;
    press();
    for (int k = 1; k <= DF; k++) begin
      tick();
      checks++; if (game_state !== 2'(m_state) || car_x !== model_car_x() || player_row !== 3'(m_row))
        $display("[TB] FAIL coll_dead_k%0d: got st=%0d row=%0d x=%h expected %0d/%0d/%h",
                 k, game_state, player_row, car_x, m_state, m_row, model_car_x());
      else passes++;
    end
    tick();
    checks++; if (game_state !== 2'(m_state) || hop_phase !== 4'(m_phase))
      $display("[TB] FAIL coll_after: got st=%0d ph=%0d expected %0d/%0d", game_state, hop_phase, m_state, m_phase);
    else passes++;
  endtask

  task automatic test_ignore();
    do_reset();
    press(); press(); tick();
    press();
    repeat (HF) tick();
    checks++; if (game_state !== 2'(m_state) || player_row !== 3'(m_row))
      $display("[TB] FAIL ignore_exit: got st=%0d row=%0d expected %0d/%0d", game_state, player_row, m_state, m_row);
    else passes++;
    repeat (3) tick();
    checks++; if (game_state !== 2'd1 || player_row !== 3'd1 || hop_phase !== 4'd0)
      $display("[TB] FAIL ignore_no_hop: got st=%0d row=%0d ph=%0d expected 1/1/0", game_state, player_row, hop_phase);
    else passes++;
  endtask

  task automatic test_goal();
    bit found;
    found = 1'b0;
    do_reset();
    press();
    for (int a = 0; a < 2000 && !found; a++) begin
      if (crossing_safe()) begin
        found = 1'b1;
        for (int h = 1; h <= NL + 1; h++) begin
          press();
          repeat (HF + 1) tick();
        end
      end else begin
        tick();
      end
    end
    checks++; if (!found)
      $display("[TB] FAIL goal_window: got none expected a safe crossing within 2000 ticks");
    else passes++;
    checks++; if (score !== 8'd1 || level !== 3'd1 || player_row !== 3'd0 || game_state !== 2'd1)
      $display("[TB] FAIL goal_result: got sc=%0d lv=%0d row=%0d st=%0d expected 1/1/0/1",
               score, level, player_row, game_state);
    else passes++;
    tick();
    checks++; if (car_x !== model_car_x())
      $display("[TB] FAIL goal_speed: got %h expected %h", car_x, model_car_x());
    else passes++;
  endtask

  task automatic test_random();
    do_reset();
    for (int it = 0; it < 800; it++) begin
      if ($urandom_range(0, 2) == 0) press();
      else tick();
      checks++; if (game_state !== 2'(m_state) || player_row !== 3'(m_row) || hop_phase !== 4'(m_phase))
        $display("[TB] FAIL rand_ctrl_%0d: got st=%0d row=%0d ph=%0d expected %0d/%0d/%0d",
                 it, game_state, player_row, hop_phase, m_state, m_row, m_phase);
      else passes++;
      checks++; if (car_x !== model_car_x())
        $display("[TB] FAIL rand_cars_%0d: got %h expected %h", it, car_x, model_car_x());
      else passes++;
      checks++; if (score !== 8'(m_score) || level !== 3'(m_level) || dead !== (!GOD && m_state == 3))
        $display("[TB] FAIL rand_score_%0d: got sc=%0d lv=%0d dead=%0d expected %0d/%0d/%0d",
                 it, score, level, dead, m_score, m_level, !GOD && m_state == 3);
      else passes++;
    end
  endtask

  initial begin
    sys_rst = 1'b0; move = 1'b0; frame_tick = 1'b0;
    test_reset();
    test_wrap();
    test_hop();
    test_collision();
    test_ignore();
    test_goal();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/crossy_game_ctrl.md
Name: crossy_game_ctrl

Overview:
- Game sequencer for the crossyroad VGA demo. Owns the player row, the hop animation, per-lane car positions, collision detection, score and level.
- Advances once per video frame on a frame_tick pulse from the VGA timing side.
- Its outputs feed the pixel renderer that drives VGA_rgb.

Parameters:
- NUM_LANES, 4, number of traffic lanes. Rows: 0 is the start row, 1..NUM_LANES are traffic lanes, NUM_LANES+1 is the goal row.
- H_ACTIVE, 640, visible width in pixels; the car x wrap modulus.
- PLAYER_X, 304, player left edge in pixels.
- PLAYER_W, 32, player width in pixels.
- CAR_W, 64, car width in pixels.
- HOP_FRAMES, 8, frames per hop animation (≥1, ≤15).
- DEAD_FRAMES, 120, frames held in DEAD (≤255).

Ports:
- clk  in  1  system clock
- sys_rst  in  1  asynchronous, active-low reset
- move  in  1  raw player button, asynchronous to clk
- frame_tick  in  1  one-cycle pulse per frame, asserted at the start of vblank
- player_row  out  3  current player row, 0..NUM_LANES+1
- hop_phase  out  4  remaining hop frames; 0 when not hopping
- car_x  out  NUM_LANES*10  packed car left-edge x; lane i (1-based) occupies bits [10*i-1 : 10*(i-1)]
- score  out  8  goals reached this game, saturates at 255
- level  out  3  difficulty, saturates at 7
- game_state  out  2  IDLE=0, PLAY=1, HOP=2, DEAD=3
- dead  out  1  high while in DEAD

Behaviour:
- Reset (sys_rst low, asynchronous):
  - state IDLE; player_row 0; hop_phase 0; score 0; level 0; dead 0.
  - car_x lane i = ((i-1)*128) mod H_ACTIVE.
  - Move synchroniser and pending flag cleared.
- Input conditioning:
  - move passes through a 2-FF synchroniser, then rising-edge detect.
  - An edge sets move_pend. move_pend is consumed only as listed below.
  - A held button produces exactly one edge.
- Car update, on each frame_tick when the state is not DEAD:
  - Lane speed s = i + level px/frame.
  - Odd lanes move right: x' = x+s, minus H_ACTIVE if x+s ≥ H_ACTIVE.
  - Even lanes move left: x' = x−s if x ≥ s, else x + H_ACTIVE − s.
  - Use 11-bit intermediates.
  - In DEAD, cars are frozen.
- Collision:
  - Evaluated on frame_tick in PLAY or HOP using the post-update car_x and the post-update player_row.
  - Hit when player_row is in 1..NUM_LANES, car_x[row] < PLAYER_X+PLAYER_W, and car_x[row]+CAR_W > PLAYER_X (11-bit compare).
  - No wrap-split overlap is considered.
  - A hit forces DEAD on the same edge, overriding every other transition; dead_cnt loads DEAD_FRAMES; move_pend clears.
- FSM:
  - IDLE: a move edge → PLAY; score clears to 0, level clears to 0, move_pend clears.
  - PLAY: on frame_tick with move_pend → HOP; player_row +1; hop_phase = HOP_FRAMES−1; move_pend clears. Collision is checked on the new row in that same tick.
  - HOP: each frame_tick decrements hop_phase. When hop_phase is 0 on a tick → PLAY. Edges arriving in HOP are discarded (move_pend held 0).
  - Goal: when player_row == NUM_LANES+1 on the HOP→PLAY transition, score +1 (sat), level +1 (sat), player_row → 0.
  - DEAD: dead=1; dead_cnt decrements per frame_tick. At 0 → IDLE with player_row 0. score and level hold so the renderer can display them. Move edges are ignored.
- Simultaneous events: a move edge and a frame_tick in the same cycle count as pending for that tick.
- Latency: all outputs are registered and update on the clk edge that samples frame_tick (or the move edge, for IDLE→PLAY).

Optional Feature:
- CROSSY_GODMODE_EN defined: the collision compare is forced false, DEAD is unreachable, and dead is constant 0.
- Undefined: normal collision behaviour as specified above.

Decomposition:
- Package crossyroad_pkg holds:
  - game-state encoding (IDLE/PLAY/HOP/DEAD);
  - COORD_W=10;
  - the H_ACTIVE default;
  - the lane-direction rule (odd = right).
- Sub-module crossy_lane_car, instantiated once per lane:
  - inputs lane index, level, frame_tick, freeze;
  - holds one car_x register plus the wrap arithmetic;
  - outputs x and the overlap flag.

Test Plan:
- Reset: assert sys_rst low mid-HOP → all outputs return to their reset values immediately (async). car_x = {384,256,128,0} packed as lane4..lane1.
- Wrap: lane 1 at x=639, level 0 → next tick x=0. Lane 2 at x=1, s=2 → next tick x=639.
- Hop: in PLAY press move once and hold 50 ticks → exactly one hop. player_row=1 on the next tick; hop_phase 7→0 over 8 ticks; then PLAY.
- Collision: from reset start a game, then hop into lane 1 so the landing tick gives car_x[lane1]=241 → DEAD and dead=1 that tick. Cars freeze; IDLE follows after 120 ticks.
- Goal: with CROSSY_GODMODE_EN, hop 5 times → after the 5th hop ends, score=1, level=1, player_row=0. Lane 1 speed becomes 2.
- Ignore: move edges during HOP and DEAD → no extra hop; move_pend is 0 on exit.
